frame_rx: RTL and testbench

Parametrised byte-stuffed frame receiver; the next-generation deframer for the host byte link. Consumes a qualified byte stream (FLAG-delimited, ESC/XOR-mask stuffed), unstuffs into a working buffer and publishes complete frames to a holding register with a valid/ack handshake. Adds shared-flag handling, abort and overflow detection, and back-pressure with explicit drop reporting. Sits between the link byte source and the accelerator command decoder.

---
 rtl/frame_pkg.sv | 16 +
 rtl/frame_rx_if.sv | 29 ++
 rtl/frame_rx.sv | 151 +++++++++++++++
 tb/tb_frame_rx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared framing constants and receiver state encoding for the host byte link.
// Used by the deframer now and by the frame transmitter later.
package frame_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    DATA    = 2'd1,
    ESCAPE  = 2'd2,
    DISCARD = 2'd3
  } rx_state_e;

  localparam logic [7:0] FLAG_BYTE = 8'h7E;
  localparam logic [7:0] ESC_BYTE  = 8'h7D;
  localparam logic [7:0] ESC_XMASK = 8'h20;

endpackage

// File: rtl/frame_rx_if.sv
// Byte-in / frame-out bundle of the deframer; slave is the receiver side,
// master is the byte source plus frame consumer.
interface frame_rx_if #(
  parameter int MAX_BYTES = 8
);
  localparam int CW = $clog2(MAX_BYTES) + 1;

  logic [7:0]    din;
  logic          din_valid;
  logic [7:0]    dout [0:MAX_BYTES-1];
  logic [CW-1:0] len;
  logic          frame_valid;
  logic          frame_ack;
  logic          err_overflow;
  logic          err_abort;
  logic          err_drop;
  logic          busy;

  modport master (
    output din, din_valid, frame_ack,
    input  dout, len, frame_valid, err_overflow, err_abort, err_drop, busy
  );

  modport slave (
    input  din, din_valid, frame_ack,
    output dout, len, frame_valid, err_overflow, err_abort, err_drop, busy
  );

endinterface

// File: rtl/frame_rx.sv
// Byte-stuffed frame receiver: frame published the edge its closing FLAG is sampled.
// No input stall; a frame closing while the holding register is unacked is dropped.
module frame_rx
  import frame_pkg::*;
#(
  parameter int         MAX_BYTES = 8,
  parameter logic [7:0] FLAG      = FLAG_BYTE,
  parameter logic [7:0] ESC       = ESC_BYTE,
  parameter logic [7:0] XMASK     = ESC_XMASK
) (
  input  logic      clk,
  input  logic      reset,
  frame_rx_if.slave bus
);
  localparam int CW = $clog2(MAX_BYTES) + 1;

  rx_state_e     state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    buf_q  [0:MAX_BYTES-1];
  logic [7:0]    buf_d  [0:MAX_BYTES-1];
  logic [7:0]    dout_q [0:MAX_BYTES-1];
  logic [7:0]    dout_d [0:MAX_BYTES-1];
  logic [CW-1:0] len_q, len_d;
  logic          fv_q, fv_d;
  logic          ovf_q, ovf_d;
  logic          abort_q, abort_d;
  logic          drop_q, drop_d;

  logic          store;
  logic [7:0]    store_val;
  logic          clear;
  logic          publish;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    buf_d     = buf_q;
    dout_d    = dout_q;
    len_d     = len_q;
    fv_d      = fv_q & ~bus.frame_ack;
    ovf_d     = 1'b0;
    abort_d   = 1'b0;
    drop_d    = 1'b0;
    store     = 1'b0;
    store_val = bus.din;
    clear     = 1'b0;
    publish   = 1'b0;

    if (bus.din_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.din == FLAG) begin
            state_d = DATA;
            clear   = 1'b1;
          end
        end
        DATA: begin
          if (bus.din == FLAG) begin
            // closing flag doubles as the opener of the next frame
            publish = (count_q != '0);
            clear   = 1'b1;
          end else if (bus.din == ESC) begin
            state_d = ESCAPE;
          end else begin
            store = 1'b1;
          end
        end
        ESCAPE: begin
          if (bus.din == FLAG) begin
            abort_d = 1'b1;
            state_d = DATA;
            clear   = 1'b1;
          end else begin
            store     = 1'b1;
            store_val = bus.din ^ XMASK;
          end
        end
        DISCARD: begin
          if (bus.din == FLAG) begin
            state_d = DATA;
            clear   = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (store) begin
      if (count_q < CW'(MAX_BYTES)) begin
        for (int i = 0; i < MAX_BYTES; i++) begin
          if (count_q == CW'(i)) buf_d[i] = store_val;
        end
        count_d = count_q + CW'(1);
        state_d = DATA;
      end else begin
        ovf_d   = 1'b1;
        state_d = DISCARD;
      end
    end

    // publish reads the pre-clear buffer, so ordering against clear is safe
    if (publish) begin
      if (!fv_q || bus.frame_ack) begin
        dout_d = buf_q;
        len_d  = count_q;
        fv_d   = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end

    if (clear) begin
      count_d = '0;
      buf_d   = '{default: 8'h00};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      count_q <= '0;
      buf_q   <= '{default: 8'h00};
      dout_q  <= '{default: 8'h00};
      len_q   <= '0;
      fv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      abort_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      buf_q   <= buf_d;
      dout_q  <= dout_d;
      len_q   <= len_d;
      fv_q    <= fv_d;
      ovf_q   <= ovf_d;
      abort_q <= abort_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.len          = len_q;
  assign bus.frame_valid  = fv_q;
  assign bus.err_overflow = ovf_q;
  assign bus.err_abort    = abort_q;
  assign bus.err_drop     = drop_q;
  assign bus.busy         = (state_q == ESCAPE) || (state_q == DISCARD) ||
                            ((state_q == DATA) && (count_q != '0));

endmodule

// File: tb/tb_frame_rx.sv
// Directed bench for frame_rx with MAX_BYTES=8; expectations are hand-computed.
module tb_frame_rx;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  frame_rx_if #(.MAX_BYTES(8)) bus ();

  frame_rx #(.MAX_BYTES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dout_word();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[55:0], bus.dout[i]};
    return r;
  endfunction

  // Byte presented at the next rising edge; outputs observed 1 time unit later.
  task automatic send(input logic [7:0] b, input logic ack = 1'b0);
    @(negedge clk);
    bus.din       = b;
    bus.din_valid = 1'b1;
    bus.frame_ack = ack;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.frame_ack = 1'b0;
  endtask

  task automatic ack_frame();
    @(negedge clk);
    bus.frame_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    clk           = 1'b0;
    reset         = 1'b1;
    bus.din       = 8'h00;
    bus.din_valid = 1'b0;
    bus.frame_ack = 1'b0;

    // reset state
    #12;
    check("rst_fv",    bus.frame_valid, 0);
    check("rst_len",   bus.len, 0);
    check("rst_dout",  dout_word(), 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_err",   {bus.err_overflow, bus.err_abort, bus.err_drop}, 0);
    @(negedge clk);
    reset = 1'b0;

    // basic frame
    send(8'h7E); send(8'h01); send(8'h02); send(8'h03);
    check("basic_fv_early", bus.frame_valid, 0);
    check("basic_busy",     bus.busy, 1);
    send(8'h7E);
    check("basic_fv",   bus.frame_valid, 1);
    check("basic_len",  bus.len, 3);
    check("basic_dout", dout_word(), 64'h0102030000000000);
    check("basic_idle", bus.busy, 0);
    ack_frame();
    check("ack_fv",  bus.frame_valid, 0);
    check("ack_len", bus.len, 3);

    // repeated flags and escapes with gaps in din_valid
    send(8'h7E); send(8'h7E);
    check("flags_no_frame", bus.frame_valid, 0);
    send(8'h7D); idle(2); send(8'h5E); idle(2);
    send(8'h7D); idle(2); send(8'h5D); idle(2);
    send(8'h20); idle(2);
    check("gap_no_frame", bus.frame_valid, 0);
    send(8'h7E);
    check("esc_fv",   bus.frame_valid, 1);
    check("esc_len",  bus.len, 3);
    check("esc_dout", dout_word(), 64'h7E7D200000000000);
    ack_frame();

    // exactly full frame
    for (int i = 1; i <= 8; i++) send(8'(i));
    check("full_no_ovf", bus.err_overflow, 0);
    send(8'h7E);
    check("full_len",  bus.len, 8);
    check("full_dout", dout_word(), 64'h0102030405060708);
    ack_frame();

    // overflow on ninth byte
    send(8'h7E);
    for (int i = 0; i < 8; i++) send(8'h11 + 8'(i));
    check("ovf_pre", bus.err_overflow, 0);
    send(8'h19);
    check("ovf_pulse", bus.err_overflow, 1);
    check("ovf_busy",  bus.busy, 1);
    send(8'h7E);
    check("ovf_clear",    bus.err_overflow, 0);
    check("ovf_no_frame", bus.frame_valid, 0);
    send(8'h55); send(8'h7E);
    check("ovf_next_len",  bus.len, 1);
    check("ovf_next_dout", dout_word(), 64'h5500000000000000);
    ack_frame();

    // abort
    send(8'h7E); send(8'h01); send(8'h7D);
    check("esc_busy", bus.busy, 1);
    send(8'h7E);
    check("abort_pulse", bus.err_abort, 1);
    check("abort_no_fr", bus.frame_valid, 0);
    send(8'h02);
    check("abort_clear", bus.err_abort, 0);
    send(8'h7E);
    check("abort_len",  bus.len, 1);
    check("abort_dout", dout_word(), 64'h0200000000000000);
    ack_frame();

    // back-pressure: drop, then accept with same-edge ack
    send(8'h7E); send(8'hAA); send(8'h7E);
    check("bp_first", dout_word(), 64'hAA00000000000000);
    send(8'hBB); send(8'h7E);
    check("bp_drop",      bus.err_drop, 1);
    check("bp_hold_dout", dout_word(), 64'hAA00000000000000);
    check("bp_hold_fv",   bus.frame_valid, 1);
    send(8'hBB); send(8'h7E, 1'b1);
    check("bp_ack_nodrop", bus.err_drop, 0);
    check("bp_ack_fv",     bus.frame_valid, 1);
    check("bp_ack_dout",   dout_word(), 64'hBB00000000000000);

    // asynchronous reset mid-frame with a frame still held
    send(8'h01); send(8'h02);
    check("mid_busy", bus.busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_fv",   bus.frame_valid, 0);
    check("mid_rst_dout", dout_word(), 0);
    check("mid_rst_len",  bus.len, 0);
    check("mid_rst_busy", bus.busy, 0);
    @(negedge clk);
    reset = 1'b0;
    send(8'h03); send(8'h7E);
    check("hunt_no_frame", bus.frame_valid, 0);
    send(8'h04); send(8'h7E);
    check("post_rst_fv",   bus.frame_valid, 1);
    check("post_rst_len",  bus.len, 1);
    check("post_rst_dout", dout_word(), 64'h0400000000000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
